// File: rtl/operand_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared DATA_W operand bus ahead of the ALU.
// Latency: grant 1 cycle after request; data_out/valid_out 1 cycle after each beat.
// Backpressure: none downstream; requesters hold reqN until their transfer ends.
// Optional ARB_TIMEOUT_EN: owner is preempted after MAX_HOLD beats while the peer waits.
module operand_bus_arbiter #(
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              last0,
    input  logic              last1,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Preemption is a single elaboration-time switch so the rest of the
    // logic reads the same in both builds; the disabled path folds away.
`ifdef ARB_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    // Beat count at which the current owner must give way to a waiting peer.
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_prio;        // 0: requester 0 wins a tie, 1: requester 1
    logic                w_prio_nxt;
    logic [7:0]          r_hold_cnt;    // beats granted while the peer is waiting
    logic [7:0]          w_hold_nxt;

    logic                r_gnt0;
    logic                r_gnt1;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;

    logic                w_own;         // some requester owns the bus
    logic                w_owner;       // which one: 0 or 1
    logic                w_req_own;
    logic                w_last_own;
    logic                w_req_peer;
    logic [DATA_W-1:0]   w_data_own;
    logic                w_beat;        // owner presents a word this cycle
    logic                w_timeout;     // owner forced off the bus this cycle
    logic                w_release;     // ownership ends on this edge

    // Owner-relative view of the request/data inputs.
    always_comb begin
        w_own      = (r_state != ST_IDLE);
        w_owner    = (r_state == ST_OWN1);
        w_req_own  = w_owner ? req1     : req0;
        w_last_own = w_owner ? last1    : last0;
        w_req_peer = w_owner ? req0     : req1;
        w_data_own = w_owner ? data_in1 : data_in0;
    end

    // Classify the current cycle: beat, preemption and release.
    always_comb begin
        w_beat    = w_own & w_req_own;
        w_timeout = TIMEOUT_EN & w_beat & w_req_peer & (r_hold_cnt == HOLD_LIMIT);
        // Withdrawal, final beat or preemption all end the ownership.
        w_release = w_own & (~w_req_own | w_last_own | w_timeout);
    end

    // Next-state and priority: tie in IDLE goes to prio, release hands to a waiting peer.
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_state_nxt = r_prio ? ST_OWN1 : ST_OWN0;
                end else if (req0) begin
                    w_state_nxt = ST_OWN0;
                end else if (req1) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (w_release) begin
                    // Peer gets the next tie, so a quick re-request by the
                    // old owner cannot starve it.
                    w_prio_nxt = ~w_owner;
                    if (w_req_peer) begin
                        // Back-to-back handoff, no idle bubble.
                        w_state_nxt = w_owner ? ST_OWN0 : ST_OWN1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Hold counter: counts contended beats, saturates, clears on release.
    always_comb begin
        w_hold_nxt = r_hold_cnt;
        if (w_release) begin
            w_hold_nxt = 8'd0;
        end else if (w_beat && w_req_peer && (r_hold_cnt != 8'hFF)) begin
            w_hold_nxt = r_hold_cnt + 8'd1;
        end
    end

    // State, priority and hold counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_prio     <= 1'b0;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Grant flops track the next state so gnt/sel come straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
        end else begin
            r_gnt0 <= (w_state_nxt == ST_OWN0);
            r_gnt1 <= (w_state_nxt == ST_OWN1);
        end
    end

    // Output word: capture on a beat, otherwise hold; valid only follows a beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_beat;
            if (w_beat) begin
                r_data <= w_data_own;
            end
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign sel       = r_gnt1;
    assign data_out  = r_data;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Directed bench for operand_bus_arbiter: expected beats queued at stimulus time,
// checked by an independent negedge monitor; grants/reset checked inline.
// Timeout scenario adapts to whether ARB_TIMEOUT_EN is defined.
module tb_operand_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        req0;
    logic        req1;
    logic        last0;
    logic        last1;
    logic [15:0] data_in0;
    logic [15:0] data_in1;
    logic        gnt0;
    logic        gnt1;
    logic        sel;
    logic [15:0] data_out;
    logic        valid_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_d;

    operand_bus_arbiter #(
        .DATA_W   (16),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .last0     (last0),
        .last1     (last1),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every cycle with valid_out high is one beat.
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat_unexpected: data_out=%0d but no beat expected at %0t", data_out, $time);
            end else begin
                exp_d = exp_q.pop_front();
                chk16("beat_data", data_out, exp_d);
            end
        end
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        data_in0 = 16'd0; data_in1 = 16'd0;

        // Reset values while rst is held.
        #3;
        chk1 ("rst_gnt0",  gnt0, 1'b0);
        chk1 ("rst_gnt1",  gnt1, 1'b0);
        chk1 ("rst_sel",   sel, 1'b0);
        chk1 ("rst_valid", valid_out, 1'b0);
        chk16("rst_data",  data_out, 16'd0);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        cyc();
        chk1 ("idle_gnt0",  gnt0, 1'b0);
        chk1 ("idle_gnt1",  gnt1, 1'b0);
        chk1 ("idle_valid", valid_out, 1'b0);
        chk16("idle_data",  data_out, 16'd0);

        // Single one-beat grant to requester 0.
        req0 = 1'b1; data_in0 = 16'd4; last0 = 1'b1;
        exp_q.push_back(16'd4);
        cyc();
        chk1("single_gnt0", gnt0, 1'b1);
        chk1("single_gnt1", gnt1, 1'b0);
        cyc();
        req0 = 1'b0; last0 = 1'b0;
        chk1("single_valid",   valid_out, 1'b1);
        chk1("single_release", gnt0, 1'b0);
        cyc();
        chk1 ("single_idle_valid", valid_out, 1'b0);
        chk16("single_data_hold",  data_out, 16'd4);

        // Asynchronous reset mid-cycle clears outputs immediately.
        #2;
        rst = 1'b1;
        #1;
        chk16("async_rst_data",  data_out, 16'd0);
        chk1 ("async_rst_valid", valid_out, 1'b0);
        chk1 ("async_rst_gnt0",  gnt0, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();

        // Tie after reset: requester 0 first, then back-to-back requester 1.
        req0 = 1'b1; req1 = 1'b1; data_in0 = 16'd7; data_in1 = 16'd6;
        last0 = 1'b1; last1 = 1'b1;
        exp_q.push_back(16'd7);
        exp_q.push_back(16'd6);
        cyc();
        chk1("tie_gnt0", gnt0, 1'b1);
        chk1("tie_gnt1", gnt1, 1'b0);
        cyc();
        req0 = 1'b0; last0 = 1'b0;
        chk1("tie_handoff_gnt1", gnt1, 1'b1);
        chk1("tie_handoff_sel",  sel, 1'b1);
        chk1("tie_handoff_gnt0", gnt0, 1'b0);
        chk1("tie_first_valid",  valid_out, 1'b1);
        cyc();
        req1 = 1'b0; last1 = 1'b0;
        chk1("tie_no_bubble", valid_out, 1'b1);
        chk1("tie_end_gnt1",  gnt1, 1'b0);

        // Fairness: both request again, prio now points back at requester 0.
        req0 = 1'b1; req1 = 1'b1; data_in0 = 16'd9; data_in1 = 16'd10;
        last0 = 1'b1; last1 = 1'b1;
        exp_q.push_back(16'd9);
        exp_q.push_back(16'd10);
        cyc();
        chk1("fair_gnt0", gnt0, 1'b1);
        chk1("fair_gnt1", gnt1, 1'b0);
        cyc();
        req0 = 1'b0; last0 = 1'b0;
        cyc();
        req1 = 1'b0; last1 = 1'b0;

        // Withdraw: requester 1 drops req1 without last1 while 0 waits.
        req1 = 1'b1; last1 = 1'b0; data_in1 = 16'd3;
        exp_q.push_back(16'd3);
        cyc();
        chk1("wd_gnt1", gnt1, 1'b1);
        cyc();
        req1 = 1'b0;
        req0 = 1'b1; last0 = 1'b1; data_in0 = 16'd8;
        exp_q.push_back(16'd8);
        cyc();
        chk1("wd_no_beat", valid_out, 1'b0);
        chk1("wd_gnt0",    gnt0, 1'b1);
        chk1("wd_gnt1",    gnt1, 1'b0);
        cyc();
        req0 = 1'b0; last0 = 1'b0;
        cyc();

        // Long burst from requester 1 while requester 0 waits.
        req1 = 1'b1; last1 = 1'b0; data_in1 = 16'd5;
        cyc();
        chk1("burst_gnt1", gnt1, 1'b1);
        req0 = 1'b1; last0 = 1'b1; data_in0 = 16'd11;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(16'd5);
        exp_q.push_back(16'd11);
        exp_q.push_back(16'd5);
        repeat (3) cyc();
        chk1("to_still_gnt1", gnt1, 1'b1);
        cyc();
        chk1("to_preempt_gnt0", gnt0, 1'b1);
        chk1("to_preempt_gnt1", gnt1, 1'b0);
        cyc();
        req0 = 1'b0; last0 = 1'b0;
        chk1("to_regrant_gnt1", gnt1, 1'b1);
        last1 = 1'b1;
        cyc();
        req1 = 1'b0; last1 = 1'b0;
        chk1("to_end_gnt1", gnt1, 1'b0);
`else
        for (int i = 0; i < 6; i++) exp_q.push_back(16'd5);
        exp_q.push_back(16'd11);
        repeat (4) cyc();
        chk1("hold_past_limit_gnt1", gnt1, 1'b1);
        cyc();
        chk1("hold_keep_gnt1", gnt1, 1'b1);
        last1 = 1'b1;
        cyc();
        req1 = 1'b0; last1 = 1'b0;
        chk1("hold_handoff_gnt0", gnt0, 1'b1);
        cyc();
        req0 = 1'b0; last0 = 1'b0;
        chk1("hold_end_gnt0", gnt0, 1'b0);
`endif
        cyc();

        // Reset in the middle of a multi-beat transfer aborts it silently.
        req0 = 1'b1; last0 = 1'b0; data_in0 = 16'd12;
        exp_q.push_back(16'd12);
        exp_q.push_back(16'd12);
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk1 ("abort_gnt0",  gnt0, 1'b0);
        chk1 ("abort_valid", valid_out, 1'b0);
        chk16("abort_data",  data_out, 16'd0);
        cyc();
        chk1("abort_held_valid", valid_out, 1'b0);
        req0 = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        chk1("post_abort_valid", valid_out, 1'b0);
        chk1("post_abort_gnt0",  gnt0, 1'b0);

        // Every queued beat must have been seen.
        repeat (2) cyc();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL beats_drained: %0d beats outstanding, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_bus_arbiter.md
Name: operand_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 16-bit operand bus built around the 2:1 operand mux.
- Two requesters (port 0: register-file read, port 1: immediate/writeback path) compete for the bus.
- The block grants one requester at a time and drives the mux select.
- It registers the selected word onto data_out with a valid strobe for the ALU input stage.

Parameters:
- DATA_W, 16, width of data_in0/data_in1/data_out.
- MAX_HOLD, 4, maximum consecutive beats one requester may hold the bus while the other waits (used only with ARB_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 wants the bus; held high until its transfer ends.
- req1  input  1  requester 1 wants the bus; held high until its transfer ends.
- last0  input  1  requester 0 marks its current beat as its final beat.
- last1  input  1  requester 1 marks its current beat as its final beat.
- data_in0  input  DATA_W  operand word from requester 0.
- data_in1  input  DATA_W  operand word from requester 1.
- gnt0  output  1  requester 0 owns the bus (registered).
- gnt1  output  1  requester 1 owns the bus (registered).
- sel  output  1  mux select; 1 selects data_in1 (registered, equals gnt1).
- data_out  output  DATA_W  registered bus word.
- valid_out  output  1  data_out holds a granted beat (registered).

Behaviour:
- Reset is asynchronous and active-high: rst=1 forces the following immediately, regardless of clk:
  - state=IDLE;
  - gnt0=0, gnt1=0, sel=0;
  - data_out=0, valid_out=0;
  - prio=0 (requester 0 wins a tie);
  - hold_cnt=0.
- Reset mid-transfer aborts the transfer silently. No beat is emitted after reset asserts.
- FSM states are IDLE, OWN0 and OWN1. gnt0=(state==OWN0) and gnt1=sel=(state==OWN1). All three are driven from state registers.
- IDLE:
  - Only req0 -> OWN0 next edge.
  - Only req1 -> OWN1 next edge.
  - Both -> the requester indicated by prio.
  - Neither -> stay in IDLE.
  - Grant latency is 1 cycle from req to gnt.
- OWNn, each cycle with reqn=1:
  - The cycle is a beat.
  - data_out <= data_inn on the edge; valid_out <= 1 on the same edge. Data latency is 1 cycle after the beat.
- OWNn with reqn=0 (requester withdrew): no beat. valid_out <= 0. Release the bus.
- OWNn with reqn=1 and lastn=1: beat is emitted, then release.
- Release from OWNn:
  - prio <= ~n.
  - hold_cnt <= 0.
  - Next state is OWN(~n) if req(~n)=1; this is a back-to-back handoff with no idle bubble.
  - Otherwise next state is IDLE.
- In IDLE, valid_out <= 0. data_out holds its last value.
- The same requester re-requesting immediately after release is not given priority over a waiting peer.
- hold_cnt is 8 bits. It increments on each beat in OWNn while req(~n)=1 and saturates at 255. It clears on release.
- Inputs are sampled only on rising clk edges. Glitches between edges are ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - When hold_cnt==MAX_HOLD-1 on a beat in OWNn and req(~n)=1, that beat is emitted and the grant is forcibly released to ~n on the same edge, exactly as a normal release.
  - The preempted requester keeps reqn high and is re-granted later by round-robin.
- Not defined: hold_cnt logic may be omitted. The owner keeps the bus until lastn or reqn drops, with no preemption.

Test Plan:
- Reset: assert rst=1 asynchronously mid-cycle -> gnt0=gnt1=sel=valid_out=0 and data_out=0 immediately; release rst, no reqs -> all outputs stay 0.
- Single grant: req0=1, data_in0=16'd4, last0=1 for 1 beat -> gnt0=1 one cycle after req0; on the next edge data_out=4 and valid_out=1; then IDLE, valid_out=0.
- Tie after reset: req0=req1=1 on the same edge, data_in0=7, data_in1=6, each last on the first beat:
  - requester 0 is granted first: data_out=7;
  - then a back-to-back grant to requester 1 with sel=1: data_out=6;
  - no idle cycle between the two beats.
- Fairness: after requester 1 finishes, req0 and req1 are both raised again -> requester 0 is granted, since prio points to 0.
- Withdraw: OWN1, drop req1 without last1 -> no beat that cycle, valid_out=0, state goes to IDLE or OWN0 per req0.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req1 held with last1=0 and data_in1=5, req0 raised during OWN1:
  - exactly 4 beats of data_out=5;
  - then gnt0=1;
  - with the macro undefined, requester 1 keeps the bus until last1.
